// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  function automatic int map_width(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int key_width(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Whole-frame debouncer: a new key map is accepted only after DEBOUNCE identical frames.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int MAP_W    = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eof,
  input  logic             abort,
  input  logic [MAP_W-1:0] frame,
  output logic [MAP_W-1:0] acc_map
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [MAP_W-1:0] prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Stable-frame count after this frame, saturating at DEBOUNCE
  always_comb begin
    cnt_next_s = cnt_r;
    if (frame == prev_r) begin
      if (cnt_r != CNT_W'(DEBOUNCE)) begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
    end else begin
      cnt_next_s = CNT_W'(1);
    end
  end

  // Frame history and accepted map
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r  <= {MAP_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      acc_map <= {MAP_W{1'b0}};
    end else if (abort) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (eof) begin
      cnt_r  <= cnt_next_s;
      prev_r <= frame;
      if ((cnt_next_s == CNT_W'(DEBOUNCE)) && (frame != acc_map)) begin
        acc_map <= frame;
      end
    end
  end

endmodule

// File: rtl/keypad_scan_debounced.sv
// ROWSxCOLS keypad scanner: row sequencer, column synchroniser, frame debounce and
// registered press/release/code reporting.
module keypad_scan_debounced
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DWELL    = 1000,
  parameter int DEBOUNCE = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                scan_en,
  input  logic [COLS-1:0]                     col_n,
  output logic [ROWS-1:0]                     row_n,
  output logic [key_width(ROWS, COLS)-1:0]    key_code,
  output logic                                key_press,
  output logic                                key_release,
  output logic                                key_held,
  output logic                                multi_key
);

  localparam int MAP_W = map_width(ROWS, COLS);
  localparam int KEY_W = key_width(ROWS, COLS);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW_W  = $clog2(DWELL);

  scan_state_t      state_r;
  logic [COLS-1:0]  col_meta_r;
  logic [COLS-1:0]  col_sync_r;
  logic [COLS-1:0]  cols_s;
  logic [ROW_W-1:0] row_idx_r;
  logic [ROW_W-1:0] row_nxt_s;
  logic [DW_W-1:0]  dwell_r;
  logic [MAP_W-1:0] frame_r;
  logic [MAP_W-1:0] frame_s;
  logic [MAP_W-1:0] acc_map_s;
  logic [KEY_W-1:0] low_idx_s;
  logic             multi_s;
  logic             eof_s;
  logic             abort_s;

  // Column synchroniser; idles at all-released so nothing looks pressed out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= {COLS{1'b1}};
      col_sync_r <= {COLS{1'b1}};
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  assign cols_s = ~col_sync_r;

  // Frame with the current row's columns merged in, plus sequencing strobes
  always_comb begin
    frame_s = frame_r;
    for (int r = 0; r < ROWS; r++) begin
      if (ROW_W'(r) == row_idx_r) begin
        frame_s[r*COLS +: COLS] = cols_s;
      end else begin
        frame_s[r*COLS +: COLS] = frame_r[r*COLS +: COLS];
      end
    end
    row_nxt_s = (row_idx_r == ROW_W'(ROWS - 1)) ? {ROW_W{1'b0}} : row_idx_r + ROW_W'(1);
    eof_s     = (state_r == ST_SCAN) && scan_en && (dwell_r == DW_W'(DWELL - 1))
                && (row_idx_r == ROW_W'(ROWS - 1));
    abort_s   = (state_r == ST_SCAN) && !scan_en;
  end

  // Row sequencer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      row_idx_r <= {ROW_W{1'b0}};
      dwell_r   <= {DW_W{1'b0}};
      frame_r   <= {MAP_W{1'b0}};
      row_n     <= {ROWS{1'b1}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          row_n <= {ROWS{1'b1}};
          if (scan_en) begin
            state_r   <= ST_SCAN;
            row_idx_r <= {ROW_W{1'b0}};
            dwell_r   <= {DW_W{1'b0}};
            row_n     <= {{(ROWS-1){1'b1}}, 1'b0};
          end
        end
        ST_SCAN: begin
          if (!scan_en) begin
            state_r   <= ST_IDLE;
            row_n     <= {ROWS{1'b1}};
            row_idx_r <= {ROW_W{1'b0}};
            dwell_r   <= {DW_W{1'b0}};
            frame_r   <= {MAP_W{1'b0}};
          end else if (dwell_r == DW_W'(DWELL - 1)) begin
            frame_r   <= frame_s;
            dwell_r   <= {DW_W{1'b0}};
            row_idx_r <= row_nxt_s;
            row_n     <= ~({{(ROWS-1){1'b0}}, 1'b1} << row_nxt_s);
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          row_n   <= {ROWS{1'b1}};
        end
      endcase
    end
  end

  keypad_frame_debounce #(
    .MAP_W    (MAP_W),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .eof     (eof_s),
    .abort   (abort_s),
    .frame   (frame_s),
    .acc_map (acc_map_s)
  );

  // Lowest set index wins; x & (x-1) is non-zero only with two or more bits set
  always_comb begin
    low_idx_s = {KEY_W{1'b0}};
    for (int i = MAP_W - 1; i >= 0; i--) begin
      if (acc_map_s[i]) begin
        low_idx_s = KEY_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
    multi_s = |(acc_map_s & (acc_map_s - MAP_W'(1)));
  end

  // Output registers; key_held doubles as the previous-map-nonzero flag for the pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= {KEY_W{1'b0}};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_held    <= |acc_map_s;
      multi_key   <= multi_s;
      key_press   <= (|acc_map_s) && !key_held;
      key_release <= !(|acc_map_s) && key_held;
      if (|acc_map_s) begin
        key_code <= low_idx_s;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounced.sv
// Scoreboard bench for keypad_scan_debounced: 4x4 main instance plus a 3x5 build.
module tb_keypad_scan_debounced;

  localparam int ROWS = 4, COLS = 4, DWELL = 8, DEBOUNCE = 3;
  localparam int FRAME = ROWS * DWELL;
  localparam int LAT = DEBOUNCE * FRAME + 1;
  localparam int R2 = 3, C2 = 5, FRAME2 = R2 * DWELL;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    logic       multi;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, scan_en;
  logic [COLS-1:0]  col_n;
  logic [ROWS-1:0]  row_n;
  logic [3:0]       key_code;
  logic             key_press, key_release, key_held, multi_key;
  logic [15:0]      keys;

  logic             rst2_n, scan_en2;
  logic [C2-1:0]    col2_n;
  logic [R2-1:0]    row2_n;
  logic [3:0]       key_code2;
  logic             press2, release2, held2, multi2;
  logic [14:0]      keys2;

  keypad_scan_debounced #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_press(key_press), .key_release(key_release),
    .key_held(key_held), .multi_key(multi_key)
  );

  keypad_scan_debounced #(.ROWS(R2), .COLS(C2), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut2 (
    .clk(clk), .rst_n(rst2_n), .scan_en(scan_en2), .col_n(col2_n), .row_n(row2_n),
    .key_code(key_code2), .key_press(press2), .key_release(release2),
    .key_held(held2), .multi_key(multi2)
  );

  // Keypad matrices: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !row_n[r]) col_n[c] = 1'b0;
    col2_n = '1;
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++)
        if (keys2[r*C2+c] && !row2_n[r]) col2_n[c] = 1'b0;
  end

  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   press2_cnt = 0, release2_cnt = 0;
  ev_t  exp_q[$], obs_q[$];
  ev_t  mon_ev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (key_press === 1'b1 || key_release === 1'b1)) begin
      mon_ev.rel   = (key_release === 1'b1);
      mon_ev.code  = key_code;
      mon_ev.multi = multi_key;
      mon_ev.cyc   = cyc;
      obs_q.push_back(mon_ev);
    end
    if (press2 === 1'b1) press2_cnt++;
    if (release2 === 1'b1) release2_cnt++;
  end

  function automatic ev_t mk_ev(bit rel, logic [3:0] code, logic multi, int at);
    ev_t e;
    e.rel = rel; e.code = code; e.multi = multi; e.cyc = at;
    return e;
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the first negedge of a fresh row-0 dwell; expiry counts as a failure
  task automatic wait_row0(output int t0);
    int k = 0;
    while (row_n === 4'b1110 && k < 200) begin @(negedge clk); k++; end
    while (row_n !== 4'b1110 && k < 200) begin @(negedge clk); k++; end
    n_chk++;
    if (row_n !== 4'b1110) $display("FAIL row0_align row_n=%b expected=1110", row_n);
    else n_pass++;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0; scan_en = 1'b0; scan_en2 = 1'b0; keys = '0; keys2 = '0;
    run(4);
    n_chk++;
    if ({row_n, key_code, key_press, key_release, key_held, multi_key} !== {4'hF, 4'h0, 4'h0})
      $display("FAIL reset_state got row_n=%b code=%0d p=%b r=%b h=%b m=%b expected row_n=1111 rest 0",
               row_n, key_code, key_press, key_release, key_held, multi_key);
    else n_pass++;
    rst_n = 1'b1;
    run(4);
    n_chk++;
    if (row_n !== 4'b1111) $display("FAIL idle_rows row_n=%b expected=1111", row_n);
    else n_pass++;
  endtask

  task automatic test_scan_no_key();
    int t0;
    logic [3:0] er;
    scan_en = 1'b1;
    wait_row0(t0);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++)
        for (int d = 0; d < DWELL; d++) begin
          er = ~(4'b0001 << r);
          if (d == 0 || d == DWELL - 1) begin
            n_chk++;
            if (row_n !== er || {key_press, key_release, key_held, multi_key, key_code} !== 8'h00)
              $display("FAIL scan_rows f%0d r%0d d%0d row_n=%b outs=%b%b%b%b code=%0d expected row_n=%b outs 0",
                       f, r, d, row_n, key_press, key_release, key_held, multi_key, key_code, er);
            else n_pass++;
          end
          @(negedge clk);
        end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL scan_no_events got %0d events expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_single_key();
    int t0;
    ev_t e, o;
    wait_row0(t0);
    keys[9] = 1'b1;
    exp_q.push_back(mk_ev(1'b0, 4'd9, 1'b0, t0 + LAT));
    run(5 * FRAME);
    n_chk++;
    if (key_held !== 1'b1 || key_code !== 4'd9 || multi_key !== 1'b0)
      $display("FAIL single_level held=%b code=%0d multi=%b expected 1/9/0", key_held, key_code, multi_key);
    else n_pass++;
    wait_row0(t0);
    keys = '0;
    exp_q.push_back(mk_ev(1'b1, 4'd9, 1'b0, t0 + LAT));
    run(5 * FRAME);
    n_chk++;
    if (key_held !== 1'b0 || key_code !== 4'd9)
      $display("FAIL single_release_level held=%b code=%0d expected 0/9", key_held, key_code);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL single_event missing rel=%0d code=%0d", e.rel, e.code);
      else begin
        o = obs_q.pop_front();
        if (o.rel != e.rel || o.code !== e.code || o.multi !== e.multi || o.cyc != e.cyc)
          $display("FAIL single_event got rel=%0d code=%0d multi=%b cyc=%0d expected rel=%0d code=%0d multi=%b cyc=%0d",
                   o.rel, o.code, o.multi, o.cyc, e.rel, e.code, e.multi, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL single_extra got %0d extra events expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int t0;
    ev_t e, o;
    wait_row0(t0);
    for (int i = 0; i < 13; i++) begin
      keys[6] = (i % 2 == 0);
      run(5);
    end
    keys[6] = 1'b1;
    exp_q.push_back(mk_ev(1'b0, 4'd6, 1'b0, -1));
    run(5 * FRAME);
    n_chk++;
    if (key_held !== 1'b1 || key_code !== 4'd6)
      $display("FAIL bounce_level held=%b code=%0d expected 1/6", key_held, key_code);
    else n_pass++;
    keys = '0;
    exp_q.push_back(mk_ev(1'b1, 4'd6, 1'b0, -1));
    run(5 * FRAME);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL bounce_event missing rel=%0d code=%0d", e.rel, e.code);
      else begin
        o = obs_q.pop_front();
        if (o.rel != e.rel || o.code !== e.code || o.multi !== e.multi)
          $display("FAIL bounce_event got rel=%0d code=%0d multi=%b expected rel=%0d code=%0d multi=%b",
                   o.rel, o.code, o.multi, e.rel, e.code, e.multi);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL bounce_extra got %0d extra events expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_multi_key();
    int t0;
    ev_t e, o;
    wait_row0(t0);
    keys[5] = 1'b1; keys[14] = 1'b1;
    exp_q.push_back(mk_ev(1'b0, 4'd5, 1'b1, -1));
    run(5 * FRAME);
    n_chk++;
    if (key_code !== 4'd5 || multi_key !== 1'b1 || key_held !== 1'b1)
      $display("FAIL multi_both code=%0d multi=%b held=%b expected 5/1/1", key_code, multi_key, key_held);
    else n_pass++;
    keys[5] = 1'b0;
    run(5 * FRAME);
    n_chk++;
    if (key_code !== 4'd14 || multi_key !== 1'b0 || key_held !== 1'b1)
      $display("FAIL multi_drop code=%0d multi=%b held=%b expected 14/0/1", key_code, multi_key, key_held);
    else n_pass++;
    keys = '0;
    exp_q.push_back(mk_ev(1'b1, 4'd14, 1'b0, -1));
    run(5 * FRAME);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL multi_event missing rel=%0d code=%0d", e.rel, e.code);
      else begin
        o = obs_q.pop_front();
        if (o.rel != e.rel || o.code !== e.code || o.multi !== e.multi)
          $display("FAIL multi_event got rel=%0d code=%0d multi=%b expected rel=%0d code=%0d multi=%b",
                   o.rel, o.code, o.multi, e.rel, e.code, e.multi);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL multi_extra got %0d extra events expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_scan_disable();
    int t0, k;
    ev_t e, o;
    wait_row0(t0);
    keys[9] = 1'b1;
    exp_q.push_back(mk_ev(1'b0, 4'd9, 1'b0, t0 + LAT));
    run(5 * FRAME);
    k = 0;
    while (row_n !== 4'b1011 && k < 100) begin @(negedge clk); k++; end
    run(3);
    scan_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (row_n !== 4'b1111 || key_held !== 1'b1)
      $display("FAIL disable_next row_n=%b held=%b expected 1111/1", row_n, key_held);
    else n_pass++;
    run(20);
    n_chk++;
    if (row_n !== 4'b1111 || key_held !== 1'b1 || key_code !== 4'd9)
      $display("FAIL disable_hold row_n=%b held=%b code=%0d expected 1111/1/9", row_n, key_held, key_code);
    else n_pass++;
    scan_en = 1'b1;
    @(negedge clk);
    n_chk++;
    if (row_n !== 4'b1110) $display("FAIL reenable_row0 row_n=%b expected 1110", row_n);
    else n_pass++;
    run(5 * FRAME);
    n_chk++;
    if (key_held !== 1'b1) $display("FAIL reenable_held held=%b expected 1", key_held);
    else n_pass++;
    keys = '0;
    exp_q.push_back(mk_ev(1'b1, 4'd9, 1'b0, -1));
    run(5 * FRAME);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) $display("FAIL disable_event missing rel=%0d code=%0d", e.rel, e.code);
      else begin
        o = obs_q.pop_front();
        if (o.rel != e.rel || o.code !== e.code || (e.cyc >= 0 && o.cyc != e.cyc))
          $display("FAIL disable_event got rel=%0d code=%0d cyc=%0d expected rel=%0d code=%0d cyc=%0d",
                   o.rel, o.code, o.cyc, e.rel, e.code, e.cyc);
        else n_pass++;
      end
    end
    n_chk++;
    if (obs_q.size() != 0) $display("FAIL disable_extra got %0d extra events expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_small_build();
    int k;
    rst2_n = 1'b1; scan_en2 = 1'b1;
    keys2[14] = 1'b1;
    run(6 * FRAME2 + 10);
    n_chk++;
    if (key_code2 !== 4'd14 || held2 !== 1'b1 || multi2 !== 1'b0 || press2_cnt != 1)
      $display("FAIL small_key code=%0d held=%b multi=%b presses=%0d expected 14/1/0/1",
               key_code2, held2, multi2, press2_cnt);
    else n_pass++;
    k = 0;
    while (row2_n !== 3'b101 && k < 100) begin @(negedge clk); k++; end
    #2 rst2_n = 1'b0;
    #1;
    n_chk++;
    if ({row2_n, key_code2, press2, release2, held2, multi2} !== {3'b111, 4'h0, 4'h0})
      $display("FAIL small_async_reset row_n=%b code=%0d p=%b r=%b h=%b m=%b expected 111 rest 0",
               row2_n, key_code2, press2, release2, held2, multi2);
    else n_pass++;
    run(5);
    n_chk++;
    if (held2 !== 1'b0 || release2_cnt != 0 || row2_n !== 3'b111)
      $display("FAIL small_no_pulse held=%b releases=%0d row_n=%b expected 0/0/111", held2, release2_cnt, row2_n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scan_no_key();
    test_single_key();
    test_bounce();
    test_multi_key();
    test_scan_disable();
    test_small_build();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
